// File: rtl/serpario_pkg.sv
// Shared types and sizing helpers for the serial-parallel I/O expander
// sequencer (74HC595 output chain, 74HC165 input chain).
package serpario_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    FINISH
  } state_t;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serpario_tick.sv
// SH_CLK phase timer: pulses phase_end on the last clk_i cycle of each
// CLK_DIV-long phase; restarts whenever the sequencer changes state.
module serpario_tick
  import serpario_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic clr,
  output logic phase_end
);

  localparam int CW = width_of(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serpario_ctrl.sv
// Turns a start request (or periodic refresh) into one full shift
// transaction on the shared 595/165 chain: shift, latch, report.
module serpario_ctrl
  import serpario_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] out_data_i,
  input  logic             oe_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] in_data_o,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             sh_clk,
  output logic             store,
  output logic             out_en
);

  localparam int BW = width_of(WIDTH);
  localparam int TW = width_of(REFRESH_CYCLES);
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
  localparam logic [TW-1:0] REF_LAST =
    TW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam bit REF_ON = (REFRESH_CYCLES > 0);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] osr;
  logic [WIDTH-1:0] osr_n;
  logic [WIDTH-1:0] isr;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bitcnt_n;
  logic [TW-1:0]    timer;
  logic             phase_end;
  logic             first_done;
  logic             ref_hit;
  logic             go;

  serpario_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .clr       (state_n != state),
    .phase_end (phase_end)
  );

  assign ref_hit = REF_ON && (timer == REF_LAST);
  assign go      = start_i || ref_hit;

  always_comb begin
    state_n  = state;
    osr_n    = osr;
    bitcnt_n = bitcnt;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n  = SHIFT_LO;
          // refresh alone replays the last word software asked for
          osr_n    = start_i ? out_data_i : word_q;
          bitcnt_n = BIT_TOP;
        end
      end
      SHIFT_LO: begin
        if (phase_end) state_n = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (bitcnt == '0) begin
            state_n = LATCH;
          end else begin
            state_n  = SHIFT_LO;
            osr_n    = {osr[WIDTH-2:0], 1'b0};
            bitcnt_n = bitcnt - 1'b1;
          end
        end
      end
      LATCH: begin
        if (phase_end) state_n = FINISH;
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state      <= IDLE;
      word_q     <= '0;
      osr        <= '0;
      isr        <= '0;
      bitcnt     <= '0;
      timer      <= '0;
      first_done <= 1'b0;
      in_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ser_out    <= 1'b0;
      sh_clk     <= 1'b0;
      store      <= 1'b0;
      out_en     <= 1'b1;
    end else begin
      state  <= state_n;
      osr    <= osr_n;
      bitcnt <= bitcnt_n;
      if (state == IDLE && start_i) begin
        word_q <= out_data_i;
      end
      if (state == IDLE) begin
        timer <= go ? '0 : timer + 1'b1;
      end
      // 165 presents its next bit until SH_CLK rises; take it on that edge
      if (state == SHIFT_LO && state_n == SHIFT_HI) begin
        isr <= {isr[WIDTH-2:0], ser_in};
      end
      if (state_n == FINISH) begin
        in_data_o  <= isr;
        first_done <= 1'b1;
      end
      // pin outputs are registered from next state so they never glitch
      busy_o  <= (state_n == SHIFT_LO) || (state_n == SHIFT_HI) ||
                 (state_n == LATCH);
      done_o  <= (state_n == FINISH);
      sh_clk  <= (state_n == SHIFT_HI);
      store   <= (state_n == LATCH);
      ser_out <= osr_n[WIDTH-1];
      out_en  <= ~(oe_i & first_done);
    end
  end

endmodule

// File: tb/tb_serpario_ctrl.sv
// Self-checking bench for serpario_ctrl with 595/165 chain models,
// a ser_out / in_data scoreboard and a refresh-enabled second instance.
module tb_serpario_ctrl;

  localparam int W   = 16;
  localparam int CD  = 4;
  localparam int LAT = 1 + 2 * CD * W + CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start;
  logic [W-1:0] out_data;
  logic         oe;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] in_data_o;
  logic         ser_in;
  logic         ser_out;
  logic         sh_clk;
  logic         store;
  logic         out_en;

  logic       rst2;
  logic       start2;
  logic [7:0] out2;
  logic       busy2;
  logic       done2;
  logic [7:0] in2;
  logic       ser_out2;
  logic       sh2;
  logic       store2;
  logic       oen2;

  serpario_ctrl #(
    .WIDTH          (W),
    .CLK_DIV        (CD),
    .REFRESH_CYCLES (0)
  ) dut (
    .clk_i      (clk),
    .reset_n    (reset_n),
    .start_i    (start),
    .out_data_i (out_data),
    .oe_i       (oe),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_data_o  (in_data_o),
    .ser_in     (ser_in),
    .ser_out    (ser_out),
    .sh_clk     (sh_clk),
    .store      (store),
    .out_en     (out_en)
  );

  serpario_ctrl #(
    .WIDTH          (8),
    .CLK_DIV        (1),
    .REFRESH_CYCLES (200)
  ) dut2 (
    .clk_i      (clk),
    .reset_n    (rst2),
    .start_i    (start2),
    .out_data_i (out2),
    .oe_i       (1'b0),
    .busy_o     (busy2),
    .done_o     (done2),
    .in_data_o  (in2),
    .ser_in     (1'b0),
    .ser_out    (ser_out2),
    .sh_clk     (sh2),
    .store      (store2),
    .out_en     (oen2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 165 input chain and 595 output chain models
  logic [W-1:0] pre165 = '0;
  logic [W-1:0] sr165 = '0;
  logic [W-1:0] sr595 = '0;
  logic [W-1:0] lat595 = '0;
  logic [7:0]   sr2 = '0;
  logic [7:0]   lat2 = '0;

  assign ser_in = sr165[W-1];

  always @(posedge sh_clk or posedge store) begin
    if (store) sr165 <= pre165;
    else       sr165 <= {sr165[W-2:0], 1'b0};
  end

  always @(posedge sh_clk) sr595 <= {sr595[W-2:0], ser_out};
  always @(posedge store)  lat595 <= sr595;
  always @(posedge sh2)    sr2 <= {sr2[6:0], ser_out2};
  always @(posedge store2) lat2 <= sr2;

  // scoreboard
  logic         exp_bits[$];
  logic [W-1:0] exp_in_q[$];
  logic         sh_prev = 1'b0;

  task automatic expect_xfer(input logic [W-1:0] word,
                             input logic [W-1:0] exp_in);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(word[i]);
    exp_in_q.push_back(exp_in);
  endtask

  always @(posedge clk) begin
    #1;
    if (sh_clk && !sh_prev) begin
      if (exp_bits.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ser_out: unexpected sh_clk edge, got %b, want none",
                 ser_out);
      end else begin
        check("ser_out", 32'(ser_out), 32'(exp_bits.pop_front()));
      end
    end
    sh_prev = sh_clk;
    if (done_o) begin
      n_done++;
      if (exp_in_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_o: unexpected pulse, got 1, want 0");
      end else begin
        check("in_data_o", 32'(in_data_o), 32'(exp_in_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [W-1:0] out_word;
    logic [W-1:0] pre;
    logic [W-1:0] exp_in;
  } vec_t;

  vec_t vecs[5];
  int   n, st_cyc, bz_cyc, en_seen, d1, d2, gap, dn0;

  initial begin
    vecs[0] = '{16'hA5C3, 16'h3C96, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'h3C96};
    vecs[2] = '{16'h0000, 16'h8000, 16'h0001};
    vecs[3] = '{16'h8001, 16'hFFFF, 16'h8000};
    vecs[4] = '{16'h1234, 16'h0000, 16'hFFFF};

    reset_n  = 1'b0;
    start    = 1'b0;
    out_data = '0;
    oe       = 1'b1;
    rst2     = 1'b0;
    start2   = 1'b0;
    out2     = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_in_data", 32'(in_data_o), 0);
    check("rst_ser_out", 32'(ser_out), 0);
    check("rst_sh_clk", 32'(sh_clk), 0);
    check("rst_store", 32'(store), 0);
    check("rst_out_en", 32'(out_en), 1);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      out_data = vecs[i].out_word;
      pre165   = vecs[i].pre;
      expect_xfer(vecs[i].out_word, vecs[i].exp_in);
      start = 1'b1;
      step();
      start    = 1'b0;
      out_data = ~vecs[i].out_word;
      n = 1; st_cyc = 0; bz_cyc = 0; en_seen = 0;
      while (!done_o && n < 400) begin
        if (store)   st_cyc++;
        if (busy_o)  bz_cyc++;
        if (!out_en) en_seen++;
        step();
        n++;
      end
      check("done_latency", n, LAT);
      check("store_width", st_cyc, CD);
      check("busy_cycles", bz_cyc, LAT - 1);
      check("busy_at_done", 32'(busy_o), 0);
      check("lat595", 32'(lat595), 32'(vecs[i].out_word));
      if (i == 0) check("out_en_before_done", en_seen, 0);
      step();
      check("out_en_after_done", 32'(out_en), 0);
      check("bits_left", exp_bits.size(), 0);
    end

    oe = 1'b0;
    step();
    check("out_en_oe_drop", 32'(out_en), 1);
    oe = 1'b1;
    step();
    check("out_en_oe_restore", 32'(out_en), 0);

    // start held through a transfer: exactly one transfer
    pre165   = 16'h5A5A;
    out_data = 16'hC001;
    dn0      = n_done;
    expect_xfer(16'hC001, 16'h0000);
    start = 1'b1;
    n = 0;
    while (!done_o && n < 400) begin
      step();
      n++;
      if (n == 50) start = 1'b0;
    end
    check("held_latency", n, LAT);
    bz_cyc = 0;
    repeat (20) begin
      step();
      if (busy_o) bz_cyc++;
    end
    check("held_single_xfer", n_done - dn0, 1);
    check("held_no_rerun", bz_cyc, 0);

    // start held across done: back-to-back with one IDLE cycle
    expect_xfer(16'hC001, 16'h5A5A);
    expect_xfer(16'hC001, 16'h5A5A);
    start = 1'b1;
    n = 0; d1 = 0; d2 = 0; gap = 0;
    while (d2 == 0 && n < 700) begin
      step();
      n++;
      if (done_o) begin
        if (d1 == 0) d1 = n;
        else         d2 = n;
      end
      if (d1 != 0 && n > d1 && !busy_o && !done_o) gap++;
      if (d1 != 0 && n > d1 + 1) start = 1'b0;
    end
    check("b2b_first_done", d1, LAT);
    check("b2b_second_done", d2, 2 * LAT + 1);
    check("b2b_idle_gap", gap, 1);
    step();
    step();
    check("b2b_stops", 32'(busy_o), 0);

    // reset during SHIFT_HI of bit 7
    pre165   = 16'hFFFF;
    out_data = 16'h0F0F;
    expect_xfer(16'h0F0F, 16'h5A5A);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (n < 1 + 2 * CD * 7 + CD + 1) begin
      step();
      n++;
    end
    check("pre_reset_sh_clk", 32'(sh_clk), 1);
    reset_n = 1'b0;
    step();
    exp_bits.delete();
    exp_in_q.delete();
    check("mid_rst_sh_clk", 32'(sh_clk), 0);
    check("mid_rst_store", 32'(store), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_out_en", 32'(out_en), 1);
    check("mid_rst_in_data", 32'(in_data_o), 0);
    step();
    reset_n = 1'b1;
    dn0 = n_done; bz_cyc = 0;
    repeat (150) begin
      step();
      if (busy_o) bz_cyc++;
    end
    check("post_rst_no_done", n_done - dn0, 0);
    check("post_rst_idle", bz_cyc, 0);
    check("post_rst_in_data", 32'(in_data_o), 0);

    // refresh instance: 8 bits, CLK_DIV=1, period 200 idle cycles
    rst2 = 1'b1;
    n = 0;
    while (!busy2 && n < 400) begin step(); n++; end
    check("ref_first_start", n, 200);
    while (!done2 && n < 600) begin step(); n++; end
    check("ref_first_done", n, 217);
    check("ref_word_reset", 32'(lat2), 0);
    bz_cyc = 0;
    while (n < 417) begin
      step();
      n++;
      if (busy2) bz_cyc++;
    end
    check("ref_idle_wait", bz_cyc, 0);
    start2 = 1'b1;
    out2   = 8'hB4;
    step();
    n++;
    start2 = 1'b0;
    out2   = 8'h0F;
    check("ref_coinc_busy", 32'(busy2), 1);
    while (!done2 && n < 800) begin step(); n++; end
    check("ref_coinc_done", n, 435);
    check("ref_coinc_word", 32'(lat2), 32'h00B4);
    step();
    n++;
    while (!busy2 && n < 900) begin step(); n++; end
    check("ref_next_start", n, 636);
    while (!done2 && n < 900) begin step(); n++; end
    check("ref_next_done", n, 653);
    check("ref_reuse_word", 32'(lat2), 32'h00B4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
